// File: rtl/NetworkPkg.sv
// Shared link-layer constants and the transmitter state type.
//   SYNCWORD       : frame marker sent ahead of every payload, MSB first
//   SYNC_BITS      : width of SYNCWORD
//   ENC_DATA_BITS  : width of one encoded payload
//   tx_state_t     : transmitter FSM states
package NetworkPkg;

  localparam int SYNC_BITS     = 8;
  localparam int ENC_DATA_BITS = 16;

  // MSB is 1 so a zero-filled receiver window cannot match on a partial syncword.
  localparam logic [SYNC_BITS-1:0] SYNCWORD = 8'hD3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    SYNC = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } tx_state_t;

  // Count value seen on the final cycle of a phase that lasts len cycles.
  function automatic logic [7:0] last_count(input int len);
    return (len > 0) ? 8'(len - 1) : 8'd0;
  endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear.
//   clk, rst_l : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment enable
//   count      : current value
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/shift_reg.sv
// Parallel-load, shift-left register; the serial bit is q[WIDTH-1].
//   clk, rst_l : clock, async active-low reset
//   load       : capture d (wins over shift)
//   shift      : shift one place toward the MSB, zero fill
//   d          : parallel load value
//   q          : register contents
module shift_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/data_transmitter.sv
// Serial frame transmitter: LEAD_ZEROS zero bits, then SYNCWORD, then data_in,
// both MSB first, on a registered serial line.
//   clk         : clock, all state changes on rising edge
//   rst_l       : async active-low reset
//   send_start  : 1-cycle pulse, accepted in IDLE/DONE while game_active
//   game_active : low aborts any frame and holds the block idle
//   data_in     : payload, captured only on an accepted send_start
//   serial_out  : serial line, 0 when not sending
//   busy        : frame in progress
//   send_done   : frame complete, held until next accepted start or abort
//
// state | meaning
// IDLE  | waiting for send_start
// LEAD  | driving leading zeros
// SYNC  | shifting out SYNCWORD
// DATA  | shifting out the payload
// DONE  | frame finished, send_done held
module data_transmitter
  import NetworkPkg::*;
#(
  parameter int LEAD_ZEROS = 2
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     send_start,
  input  logic                     game_active,
  input  logic [ENC_DATA_BITS-1:0] data_in,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     send_done
);

  localparam int FRAME_BITS = SYNC_BITS + ENC_DATA_BITS;
  localparam logic [7:0] LEAD_LAST = last_count(LEAD_ZEROS);
  localparam logic [7:0] SYNC_LAST = last_count(SYNC_BITS);
  localparam logic [7:0] DATA_LAST = last_count(ENC_DATA_BITS);

  tx_state_t             state;
  logic [7:0]            bit_cnt;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  frame_msb;
  logic                  accept;
  logic                  state_end;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  shift_en;

  // Only the MSB of the frame register feeds the line.
  logic unused_frame_bits;
  assign unused_frame_bits = ^frame_q[FRAME_BITS-2:0];
  assign frame_msb         = frame_q[FRAME_BITS-1];

  always_comb begin
    accept    = game_active && send_start && (state == IDLE || state == DONE);
    state_end = 1'b0;
    case (state)
      LEAD:    state_end = (bit_cnt == LEAD_LAST);
      SYNC:    state_end = (bit_cnt == SYNC_LAST);
      DATA:    state_end = (bit_cnt == DATA_LAST);
      default: state_end = 1'b0;
    endcase
    // Counter restarts on every state entry, so it only ever counts within one phase.
    cnt_en   = game_active && (state == LEAD || state == SYNC || state == DATA);
    cnt_clr  = !game_active || accept || state_end;
    shift_en = game_active && (state == SYNC || state == DATA);
  end

  counter #(
    .WIDTH(8)
  ) u_bit_cnt (
    .clk  (clk),
    .rst_l(rst_l),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(bit_cnt)
  );

  shift_reg #(
    .WIDTH(FRAME_BITS)
  ) u_frame (
    .clk  (clk),
    .rst_l(rst_l),
    .load (accept),
    .shift(shift_en),
    .d    ({SYNCWORD, data_in}),
    .q    (frame_q)
  );

  // serial_out is registered from the current state, so each line bit trails
  // the state that produced it by one cycle; busy/send_done settle in DONE's
  // first edge to stay aligned with the last bit leaving the line.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      send_done  <= 1'b0;
    end else if (!game_active) begin
      state      <= IDLE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      send_done  <= 1'b0;
    end else if (accept) begin
      state      <= (LEAD_ZEROS == 0) ? SYNC : LEAD;
      serial_out <= 1'b0;
      busy       <= 1'b1;
      send_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b0;
          busy       <= 1'b0;
          send_done  <= 1'b0;
        end
        LEAD: begin
          serial_out <= 1'b0;
          if (state_end) state <= SYNC;
        end
        SYNC: begin
          serial_out <= frame_msb;
          if (state_end) state <= DATA;
        end
        DATA: begin
          serial_out <= frame_msb;
          if (state_end) state <= DONE;
        end
        DONE: begin
          serial_out <= 1'b0;
          busy       <= 1'b0;
          send_done  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b0;
          busy       <= 1'b0;
          send_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
